// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern-detect controller:
// the FSM state encoding and the pattern-length mask helper.
package seq_det_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Widest mask the helper can build; PAT_MAX must not exceed it.
  localparam int MASK_W = 32;

  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Word-input handshake between a data source and the detector controller.
interface seq_det_ctrl_if #(
  parameter int WORD_W = 8
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_det_matcher.sv
// Bit-serial matcher: history shift register, saturating bits-seen count,
// masked pattern compare and the registered match pulse.
module seq_det_matcher
  import seq_det_pkg::*;
#(
  parameter int PAT_MAX = 16,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic               squash,
  input  logic               bit_in,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit,
  output logic               det_pulse
);

  localparam logic [LEN_W-1:0] PAT_MAX_L = LEN_W'(PAT_MAX);

  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] hist_next;
  logic [PAT_MAX-1:0] mask;
  logic [MASK_W-1:0]  mask_full;
  logic [LEN_W-1:0]   seen;
  logic [LEN_W-1:0]   seen_next;
  logic [LEN_W-1:0]   len_eff;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    len_eff   = (len > PAT_MAX_L) ? PAT_MAX_L : len;
    mask_full = len_mask(32'(len_eff));
    mask      = mask_full[PAT_MAX-1:0];
    hist_next = {hist[PAT_MAX-2:0], bit_in};
    seen_next = (seen == PAT_MAX_L) ? seen : seen + LEN_W'(1);
    hit       = en && (len_eff != '0) && (seen_next >= len_eff) &&
                ((hist_next & mask) == (pattern & mask));
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist      <= '0;
      seen      <= '0;
      det_pulse <= 1'b0;
    end else begin
      if (en) begin
        hist <= hist_next;
        seen <= seen_next;
      end
      det_pulse <= hit && !squash;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Pattern-detect controller: arms on start, pulls words over the handshake,
// feeds them MSB-first to the matcher and stops at the match threshold.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               start,
  input  logic               abort,
  seq_det_ctrl_if.slave      word_bus,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
);

  localparam int               IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  state_t             state_next;
  logic [WORD_W-1:0]  word;
  logic [IDX_W-1:0]   idx;
  logic [PAT_MAX-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [CNT_W-1:0]   thresh_r;
  logic [CNT_W-1:0]   cnt_next;
  logic               cfg_open;
  logic               clear;
  logic               accept;
  logic               shift_en;
  logic               hit;
  logic               thresh_hit;

  assign cfg_open          = (state == IDLE) || (state == DONE);
  assign shift_en          = (state == SHIFT);
  assign word_bus.in_ready = (state == LOAD);
  assign busy              = (state == LOAD) || (state == SHIFT);
  assign done              = (state == DONE);

  // The bit shifted on an abort edge still counts, but its pulse is dropped.
  seq_det_matcher #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_matcher (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .en        (shift_en),
    .squash    (abort),
    .bit_in    (word[idx]),
    .pattern   (pat_r),
    .len       (len_r),
    .hit       (hit),
    .det_pulse (det_pulse)
  );

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    accept     = 1'b0;
    cnt_next   = (hit && (match_cnt != CNT_MAX)) ? match_cnt + CNT_W'(1) : match_cnt;
    thresh_hit = hit && (thresh_r != '0) && (cnt_next == thresh_r);
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = LOAD;
          clear      = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (word_bus.in_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (abort)              state_next = IDLE;
        else if (thresh_hit)    state_next = DONE;
        else if (idx == '0)     state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word      <= '0;
      idx       <= '0;
      pat_r     <= '0;
      len_r     <= '0;
      thresh_r  <= '0;
      match_cnt <= '0;
    end else begin
      state <= state_next;
      if (cfg_we && cfg_open) begin
        pat_r    <= cfg_pattern;
        len_r    <= cfg_len;
        thresh_r <= cfg_thresh;
      end
      if (accept) begin
        word <= word_bus.in_data;
        idx  <= IDX_TOP;
      end else if (shift_en) begin
        idx <= idx - IDX_W'(1);
      end
      match_cnt <= clear ? '0 : cnt_next;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a bit-queue reference model predicts
// each det_pulse (cycle and count); a monitor checks what the DUT presents.
module tb_seq_det_ctrl;

  localparam int WORD_W  = 8;
  localparam int PAT_MAX = 16;
  localparam int LEN_W   = 5;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_thresh;
  logic               start;
  logic               abort;
  logic               det_pulse;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;

  seq_det_ctrl_if #(.WORD_W(WORD_W)) word_bus ();

  seq_det_ctrl #(
    .WORD_W  (WORD_W),
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_thresh  (cfg_thresh),
    .start       (start),
    .abort       (abort),
    .word_bus    (word_bus),
    .det_pulse   (det_pulse),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: raw bit history plus configuration and phase.
  bit          hist_q[$];
  logic [15:0] m_pat;
  int          m_len;
  int          m_thr;
  int          m_cnt;
  int          m_phase;   // 0 idle, 1 armed (load/shift), 2 done
  bit          m_done;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every presented or predicted pulse.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("missed_pulse_cycle", exp_q[0].cyc, cyc);
      exp_q.delete(0);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      check("det_pulse", det_pulse, 1);
      check("pulse_cnt", match_cnt, exp_q[0].cnt);
      exp_q.delete(0);
    end else if (det_pulse) begin
      check("unexpected_pulse", det_pulse, 0);
    end
  end

  function automatic int len_eff();
    return (m_len > PAT_MAX) ? PAT_MAX : m_len;
  endfunction

  task automatic model_bit(input bit b, input int pulse_cyc, input bit squashed);
    int L;
    bit h;
    hist_q.push_back(b);
    if (hist_q.size() > PAT_MAX) hist_q.delete(0);
    L = len_eff();
    h = (L != 0) && (hist_q.size() >= L);
    for (int i = 0; i < L && h; i++) begin
      if (hist_q[hist_q.size() - 1 - i] != m_pat[i]) h = 1'b0;
    end
    if (h) begin
      if (m_cnt < 255) m_cnt++;
      if (!squashed) begin
        exp_q.push_back('{cyc: pulse_cyc, cnt: m_cnt});
        if (m_thr != 0 && m_cnt == m_thr) begin
          m_done  = 1'b1;
          m_phase = 2;
        end
      end
    end
  endtask

  // Word accepted at edge acc; bit j (MSB first) enters at edge acc+1+j.
  task automatic model_word(input logic [7:0] w, input int acc, input int abort_j);
    for (int j = 0; j < WORD_W; j++) begin
      model_bit(w[WORD_W-1-j], acc + 1 + j, j == abort_j);
      if (j == abort_j || m_done) break;
    end
  endtask

  task automatic accept_word(input logic [7:0] w, input int gap, output int acc);
    int n;
    word_bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    word_bus.in_valid = 1'b1;
    word_bus.in_data  = w;
    n = 0;
    while (!word_bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", word_bus.in_ready, 1);
    acc = cyc + 1;
    @(negedge clk);
    word_bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    int acc;
    accept_word(w, $urandom_range(0, 2), acc);
    model_word(w, acc, -1);
  endtask

  task automatic do_cfg(input logic [15:0] pat, input int len, input int thr);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_thresh  = CNT_W'(thr);
    if (m_phase != 1) begin
      m_pat = pat;
      m_len = len;
      m_thr = thr;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hist_q.delete();
    m_cnt   = 0;
    m_done  = 1'b0;
    m_phase = 1;
    check("start_cnt_clear", match_cnt, 0);
    check("start_busy", busy, 1);
  endtask

  task automatic finish_run();
    repeat (WORD_W + 2) @(negedge clk);
    if (m_phase == 2) begin
      check("done_flag", done, 1);
      check("done_busy", busy, 0);
      check("done_ready", word_bus.in_ready, 0);
      check("done_cnt", match_cnt, m_cnt);
    end else begin
      check("run_busy", busy, 1);
      check("run_ready", word_bus.in_ready, 1);
      check("run_cnt", match_cnt, m_cnt);
      abort = 1'b1;
      @(negedge clk);
      abort   = 1'b0;
      m_phase = 0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, word_bus.in_ready, 0);
    check({tag, "_pulse"}, det_pulse, 0);
    check({tag, "_cnt"}, match_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [7:0] w;
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
    start = 1'b0; abort = 1'b0;
    word_bus.in_valid = 1'b0; word_bus.in_data = '0;
    m_pat = '0; m_len = 0; m_thr = 0; m_cnt = 0; m_phase = 0; m_done = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Full-byte pattern reaching threshold 2 on the second word.
    do_cfg(16'h00B5, 8, 2);
    do_start();
    send_word(8'hB5);
    send_word(8'hB5);
    finish_run();

    // Overlapping 101 matches, no threshold; reconfigured from DONE.
    do_cfg(16'h0005, 3, 0);
    do_start();
    send_word(8'hAA);
    finish_run();

    // Match spanning a word boundary.
    do_cfg(16'h00F0, 8, 0);
    do_start();
    send_word(8'h0F);
    send_word(8'h00);
    finish_run();

    // Threshold 1 hit early in a word; rest of the word discarded.
    do_cfg(16'h0003, 2, 1);
    do_start();
    send_word(8'hFF);
    finish_run();

    // Abort at idx 4 with an ignored config write during SHIFT.
    do_cfg(16'h0001, 1, 0);
    do_start();
    accept_word(8'hE7, 0, acc);
    model_word(8'hE7, acc, 3);
    @(negedge clk);
    do_cfg(16'h0000, 1, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    m_phase = 0;
    check("abort_shift_busy", busy, 0);
    check("abort_shift_ready", word_bus.in_ready, 0);
    check("abort_shift_done", done, 0);
    check("abort_shift_cnt", match_cnt, m_cnt);
    repeat (12) @(negedge clk);
    check("abort_cnt_hold", match_cnt, m_cnt);
    check("abort_queue", exp_q.size(), 0);
    do_start();
    send_word(8'hE7);
    finish_run();

    // Reset in the middle of a word.
    do_cfg(16'h0005, 3, 0);
    do_start();
    accept_word(8'hA5, 0, acc);
    model_word(8'hA5, acc, -1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc) exp_q.delete(exp_q.size() - 1);
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;
    m_pat = '0; m_len = 0; m_thr = 0; m_cnt = 0; m_phase = 0; m_done = 1'b0;
    hist_q.delete();

    // Length 0 (config cleared by reset) never matches.
    do_start();
    send_word(8'h00);
    send_word(8'h00);
    finish_run();

    // Length 31 clamps to 16.
    do_cfg(16'hA53C, 31, 1);
    do_start();
    send_word(8'hA5);
    send_word(8'h3C);
    finish_run();

    // Randomized runs against the reference model.
    for (int r = 0; r < 30; r++) begin
      int len;
      int nw;
      if ($urandom_range(0, 9) < 7) len = $urandom_range(1, 4);
      else                          len = $urandom_range(0, 31);
      do_cfg(16'($urandom), len, $urandom_range(0, 3));
      do_start();
      nw = $urandom_range(1, 5);
      for (int k = 0; k < nw; k++) begin
        if (m_done) break;
        w = 8'($urandom);
        send_word(w);
      end
      finish_run();
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
